// File: rtl/instruction_loader_if.sv
// Byte-stream / instruction-memory-write bundle for instruction_loader.
// slave = the loader itself, master = host byte source plus memory/core side.
interface instruction_loader_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8
);
    // Handshake: a byte moves on a rising edge where in_valid and in_ready are both 1;
    // the source holds in_data/in_last stable while in_valid=1 and in_ready=0.
    logic                      start;
    logic [2*DATA_WIDTH-1:0]   in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      cpu_hold;
    logic                      done;
    logic                      overflow;
    logic [ADDR_WIDTH:0]       load_count;
    logic [2:0]                fsm_state;

    modport slave (
        input  start, in_data, in_valid, in_last,
        output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, overflow,
               load_count, fsm_state
    );

    modport master (
        output start, in_data, in_valid, in_last,
        input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, overflow,
               load_count, fsm_state
    );
endinterface

// File: rtl/instruction_loader.sv
// Unpacks a byte stream into instruction pairs and writes them to instruction RAM from 0.
// Optional zero fill of the unused tail: define INSTRUCTION_LOADER_ZERO_FILL_EN.
module instruction_loader #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    instruction_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_LO = 3'd1,
        S_LOAD_HI = 3'd2,
`ifdef INSTRUCTION_LOADER_ZERO_FILL_EN
        S_FILL    = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   addr, addr_n;
    logic [DATA_WIDTH-1:0]   hi_q, hi_n;
    logic                    last_q, last_n;
    logic                    we_q, we_n;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_n;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_n;
    logic                    ovf_q, ovf_n;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_n;
    logic [ADDR_WIDTH-1:0]   addr_hi;
    logic                    pair_fills_mem;

    // The upper instruction of the current pair lands at addr+1; if that is the top
    // address the memory is full after this pair.
    assign addr_hi        = addr + ADDR_ONE;
    assign pair_fills_mem = (addr_hi == ADDR_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr    <= '0;
            hi_q    <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            hi_q    <= hi_n;
            last_q  <= last_n;
            we_q    <= we_n;
            maddr_q <= maddr_n;
            mdata_q <= mdata_n;
            ovf_q   <= ovf_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        hi_n    = hi_q;
        last_n  = last_q;
        we_n    = 1'b0;
        maddr_n = maddr_q;
        mdata_n = mdata_q;
        ovf_n   = ovf_q;
        cnt_n   = cnt_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_n = S_LOAD_LO;
                    addr_n  = '0;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            S_LOAD_LO: begin
                if (bus.in_valid) begin
                    we_n    = 1'b1;
                    maddr_n = addr;
                    mdata_n = bus.in_data[DATA_WIDTH-1:0];
                    hi_n    = bus.in_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    last_n  = bus.in_last;
                    cnt_n   = cnt_q + CNT_ONE;
                    state_n = S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                we_n    = 1'b1;
                maddr_n = addr_hi;
                mdata_n = hi_q;
                cnt_n   = cnt_q + CNT_ONE;
                addr_n  = addr + ADDR_TWO;
                if (last_q) begin
`ifdef INSTRUCTION_LOADER_ZERO_FILL_EN
                    state_n = pair_fills_mem ? S_DONE : S_FILL;
`else
                    state_n = S_DONE;
`endif
                end else if (pair_fills_mem) begin
                    state_n = S_DONE;
                    ovf_n   = 1'b1;
                end else begin
                    state_n = S_LOAD_LO;
                end
            end
`ifdef INSTRUCTION_LOADER_ZERO_FILL_EN
            S_FILL: begin
                we_n    = 1'b1;
                maddr_n = addr;
                mdata_n = '0;
                addr_n  = addr + ADDR_ONE;
                if (addr == ADDR_MAX) begin
                    state_n = S_DONE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state == S_LOAD_LO);
    assign bus.cpu_hold   = (state != S_DONE);
    assign bus.done       = (state == S_DONE);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = maddr_q;
    assign bus.mem_data   = mdata_q;
    assign bus.overflow   = ovf_q;
    assign bus.load_count = cnt_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader (ADDR_WIDTH=4): memory writes are checked
// against an expected queue filled as bytes are driven.
module tb_instruction_loader;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam int W  = AW + DW;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] addr_m;

    instruction_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    instruction_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset infrastructure
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every memory write must match the head of exp_q
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("write_addr_data", 32'({bus.mem_addr, bus.mem_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        addr_m    = '0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap, output int acc_cyc);
        int n;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 20), 32'd1);
        acc_cyc = cyc;
        exp_q.push_back({addr_m, b[3:0]});
        exp_q.push_back({addr_m + AW'(1), b[7:4]});
        addr_m = addr_m + AW'(2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push_fill();
`ifdef INSTRUCTION_LOADER_ZERO_FILL_EN
        if (addr_m != '0) begin
            for (int a = int'(addr_m); a < (1 << AW); a++) begin
                exp_q.push_back({AW'(a), DW'(0)});
            end
        end
`endif
    endtask

    task automatic wait_done(input string tag, input int exp_cnt, input logic exp_ovf);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_load_count"}, 32'(bus.load_count), 32'(exp_cnt));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_data"}, 32'(bus.mem_data), 32'd0);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, "_load_count"}, 32'(bus.load_count), 32'd0);
        check({tag, "_state"}, 32'(bus.fsm_state), 32'd0);
    endtask

    initial begin
        int c1, c2, n;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        addr_m       = '0;

        // reset and idle
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd1);
            check("idle_mem_we", 32'(bus.mem_we), 32'd0);
        end
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // two bytes back to back with in_valid held
        do_start();
        check("load_in_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'h21, 1'b0, 0, c1);
        send_byte(8'h43, 1'b1, 0, c2);
        check("accept_spacing", 32'(c2 - c1), 32'd2);
        push_fill();
        wait_done("pair", 4, 1'b0);

        // gaps between bytes, plus a start pulse mid-load that must be ignored
        do_start();
        send_byte(8'h65, 1'b0, 0, c1);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ignored_hold", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h87, 1'b0, 3, c1);
        send_byte(8'hA9, 1'b1, 3, c2);
        push_fill();
        wait_done("gaps", 6, 1'b0);

        // memory fills before in_last: 9th byte must never be taken
        do_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0, 0, c1);
        end
        bus.in_data  = 8'($urandom_range(0, 255));
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("ovf_ninth_refused", 32'(bus.in_ready), 32'd0);
        end
        wait_done("ovf", 16, 1'b1);
        bus.in_valid = 1'b0;

        // reset while in LOAD_HI, then a clean reload from address 0
        do_start();
        bus.in_data  = 8'hCB;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_accept_timeout", 32'(n < 20), 32'd1);
        exp_q.push_back({AW'(0), DW'(4'hB)});
        @(negedge clk);
        check("rst_in_load_hi", 32'(bus.fsm_state), 32'd2);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        rst_n = 1'b1;
        do_start();
        send_byte(8'h10, 1'b0, 0, c1);
        send_byte(8'h32, 1'b1, 0, c2);
        push_fill();
        wait_done("reload", 4, 1'b0);

        // single last byte (zero fill of the tail when that feature is built in)
        do_start();
        send_byte(8'hBA, 1'b1, 0, c1);
        push_fill();
        wait_done("single", 2, 1'b0);

        repeat (3) @(negedge clk);
        check("final_no_stray_writes", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the instruction store: accepts a program as a byte stream over a valid/ready handshake.
- Unpacks each byte into two DATA_WIDTH-bit instructions and writes them sequentially into instruction RAM from address 0.
- Holds the processor core in hold until the load completes, then releases it.
- Sits between the host/UART byte source and the instruction memory write port.

Parameters:
DATA_WIDTH, 4, width of one instruction; input byte is 2*DATA_WIDTH bits
ADDR_WIDTH, 8, instruction memory address width; depth = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse, begins a new load
in_data  input  2*DATA_WIDTH  packed instruction pair, low nibble = lower address
in_valid  input  1  in_data/in_last valid
in_last  input  1  current byte is final byte of program
in_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction memory write enable (registered)
mem_addr  output  ADDR_WIDTH  write address (registered)
mem_data  output  DATA_WIDTH  write data (registered)
cpu_hold  output  1  keeps core stalled/reset while 1
done  output  1  load complete, program valid
overflow  output  1  memory filled before in_last seen
load_count  output  ADDR_WIDTH+1  number of stream instructions written in current/last load

Behaviour:
- Reset (rst_n=0 at clk edge, synchronous, overrides everything incl. mid-load):
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, overflow=0, load_count=0.
- States: IDLE, LOAD_LO, LOAD_HI, FILL (optional feature only), DONE.
- IDLE: cpu_hold=1. start=1 -> LOAD_LO; clears internal addr, load_count, overflow.
- LOAD_LO: in_ready=1 (combinational from state).
  - Transfer on in_valid&in_ready -> next cycle: mem_we=1, mem_addr=addr, mem_data=in_data[DATA_WIDTH-1:0]; upper nibble and in_last latched; load_count+1; -> LOAD_HI.
  - No transfer: mem_we=0, stay.
- LOAD_HI: in_ready=0.
  - Next cycle: mem_we=1, mem_addr=addr+1, mem_data=latched upper nibble; load_count+1; addr advances by 2.
  - Exit priority: latched last -> DONE (or FILL); else addr+1 == 2**ADDR_WIDTH-1 (memory full) -> DONE with overflow=1; else -> LOAD_LO.
- Throughput: at most one byte per 2 cycles. Write latency: 1 cycle after transfer for lower, 2 cycles for upper.
- Full memory: last write at max address. Byte arriving with in_last on the final pair: overflow=0.
- DONE: done=1, cpu_hold=0, in_ready=0, mem_we=0. Outputs held until start.
  - start -> LOAD_LO with cpu_hold=1, done=0, counters and overflow cleared.
- start while in LOAD_LO/LOAD_HI/FILL: ignored.
- Stream bytes presented outside LOAD_LO: not accepted (in_ready=0); the source must hold them.
- load_count counts stream instructions only, never fill writes; max value 2**ADDR_WIDTH.
- Address arithmetic: ADDR_WIDTH bits, never wraps during a load (full check stops it).

Optional Feature:
- Macro: INSTRUCTION_LOADER_ZERO_FILL_EN
- Defined: after a final pair that does not fill memory, enter FILL.
  - Write mem_data=0 to every remaining address, one per cycle, incrementing to 2**ADDR_WIDTH-1 inclusive, then DONE.
  - cpu_hold stays 1 and in_ready stays 0 throughout FILL.
  - overflow path skips FILL.
- Undefined: FILL state absent; last pair -> DONE directly; stale contents beyond the program are untouched.

Test Plan:
- Reset then idle 10 cycles -> cpu_hold=1, done=0, in_ready=0, mem_we never asserted.
- start; bytes 8'h21, 8'h43 (last) with in_valid held -> writes (0,1),(1,2),(2,3),(3,4) on consecutive cycles, each byte accepted every 2nd cycle; then done=1, cpu_hold=0, load_count=4, overflow=0.
- Source deasserts in_valid 3 cycles between bytes -> no extra writes, no duplicates, addresses contiguous.
- ADDR_WIDTH=4; stream 9 bytes with no in_last -> 16 writes to 0..15, 9th byte never accepted, done=1, overflow=1, load_count=16.
- Reset asserted during LOAD_HI -> next cycle all outputs at reset values; new start reloads from address 0.
- With INSTRUCTION_LOADER_ZERO_FILL_EN, ADDR_WIDTH=4, single byte 8'hBA last -> writes A@0, B@1, then 0 to addresses 2..15 one per cycle; done after address 15; load_count=2.
